// File: rtl/aes_pkg.sv
// Shared AES definitions: forward/inverse S-box tables, engine states.
// Imported by the InvSubBytes engine, its slice and its interface.
package aes_pkg;

    localparam int NBYTES = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] r;
        r = 8'h00;
        case (b)
            8'h00: r = 8'h63; 8'h01: r = 8'h7c; 8'h02: r = 8'h77; 8'h03: r = 8'h7b; 8'h04: r = 8'hf2; 8'h05: r = 8'h6b; 8'h06: r = 8'h6f; 8'h07: r = 8'hc5;
            8'h08: r = 8'h30; 8'h09: r = 8'h01; 8'h0a: r = 8'h67; 8'h0b: r = 8'h2b; 8'h0c: r = 8'hfe; 8'h0d: r = 8'hd7; 8'h0e: r = 8'hab; 8'h0f: r = 8'h76;
            8'h10: r = 8'hca; 8'h11: r = 8'h82; 8'h12: r = 8'hc9; 8'h13: r = 8'h7d; 8'h14: r = 8'hfa; 8'h15: r = 8'h59; 8'h16: r = 8'h47; 8'h17: r = 8'hf0;
            8'h18: r = 8'had; 8'h19: r = 8'hd4; 8'h1a: r = 8'ha2; 8'h1b: r = 8'haf; 8'h1c: r = 8'h9c; 8'h1d: r = 8'ha4; 8'h1e: r = 8'h72; 8'h1f: r = 8'hc0;
            8'h20: r = 8'hb7; 8'h21: r = 8'hfd; 8'h22: r = 8'h93; 8'h23: r = 8'h26; 8'h24: r = 8'h36; 8'h25: r = 8'h3f; 8'h26: r = 8'hf7; 8'h27: r = 8'hcc;
            8'h28: r = 8'h34; 8'h29: r = 8'ha5; 8'h2a: r = 8'he5; 8'h2b: r = 8'hf1; 8'h2c: r = 8'h71; 8'h2d: r = 8'hd8; 8'h2e: r = 8'h31; 8'h2f: r = 8'h15;
            8'h30: r = 8'h04; 8'h31: r = 8'hc7; 8'h32: r = 8'h23; 8'h33: r = 8'hc3; 8'h34: r = 8'h18; 8'h35: r = 8'h96; 8'h36: r = 8'h05; 8'h37: r = 8'h9a;
            8'h38: r = 8'h07; 8'h39: r = 8'h12; 8'h3a: r = 8'h80; 8'h3b: r = 8'he2; 8'h3c: r = 8'heb; 8'h3d: r = 8'h27; 8'h3e: r = 8'hb2; 8'h3f: r = 8'h75;
            8'h40: r = 8'h09; 8'h41: r = 8'h83; 8'h42: r = 8'h2c; 8'h43: r = 8'h1a; 8'h44: r = 8'h1b; 8'h45: r = 8'h6e; 8'h46: r = 8'h5a; 8'h47: r = 8'ha0;
            8'h48: r = 8'h52; 8'h49: r = 8'h3b; 8'h4a: r = 8'hd6; 8'h4b: r = 8'hb3; 8'h4c: r = 8'h29; 8'h4d: r = 8'he3; 8'h4e: r = 8'h2f; 8'h4f: r = 8'h84;
            8'h50: r = 8'h53; 8'h51: r = 8'hd1; 8'h52: r = 8'h00; 8'h53: r = 8'hed; 8'h54: r = 8'h20; 8'h55: r = 8'hfc; 8'h56: r = 8'hb1; 8'h57: r = 8'h5b;
            8'h58: r = 8'h6a; 8'h59: r = 8'hcb; 8'h5a: r = 8'hbe; 8'h5b: r = 8'h39; 8'h5c: r = 8'h4a; 8'h5d: r = 8'h4c; 8'h5e: r = 8'h58; 8'h5f: r = 8'hcf;
            8'h60: r = 8'hd0; 8'h61: r = 8'hef; 8'h62: r = 8'haa; 8'h63: r = 8'hfb; 8'h64: r = 8'h43; 8'h65: r = 8'h4d; 8'h66: r = 8'h33; 8'h67: r = 8'h85;
            8'h68: r = 8'h45; 8'h69: r = 8'hf9; 8'h6a: r = 8'h02; 8'h6b: r = 8'h7f; 8'h6c: r = 8'h50; 8'h6d: r = 8'h3c; 8'h6e: r = 8'h9f; 8'h6f: r = 8'ha8;
            8'h70: r = 8'h51; 8'h71: r = 8'ha3; 8'h72: r = 8'h40; 8'h73: r = 8'h8f; 8'h74: r = 8'h92; 8'h75: r = 8'h9d; 8'h76: r = 8'h38; 8'h77: r = 8'hf5;
            8'h78: r = 8'hbc; 8'h79: r = 8'hb6; 8'h7a: r = 8'hda; 8'h7b: r = 8'h21; 8'h7c: r = 8'h10; 8'h7d: r = 8'hff; 8'h7e: r = 8'hf3; 8'h7f: r = 8'hd2;
            8'h80: r = 8'hcd; 8'h81: r = 8'h0c; 8'h82: r = 8'h13; 8'h83: r = 8'hec; 8'h84: r = 8'h5f; 8'h85: r = 8'h97; 8'h86: r = 8'h44; 8'h87: r = 8'h17;
            8'h88: r = 8'hc4; 8'h89: r = 8'ha7; 8'h8a: r = 8'h7e; 8'h8b: r = 8'h3d; 8'h8c: r = 8'h64; 8'h8d: r = 8'h5d; 8'h8e: r = 8'h19; 8'h8f: r = 8'h73;
            8'h90: r = 8'h60; 8'h91: r = 8'h81; 8'h92: r = 8'h4f; 8'h93: r = 8'hdc; 8'h94: r = 8'h22; 8'h95: r = 8'h2a; 8'h96: r = 8'h90; 8'h97: r = 8'h88;
            8'h98: r = 8'h46; 8'h99: r = 8'hee; 8'h9a: r = 8'hb8; 8'h9b: r = 8'h14; 8'h9c: r = 8'hde; 8'h9d: r = 8'h5e; 8'h9e: r = 8'h0b; 8'h9f: r = 8'hdb;
            8'ha0: r = 8'he0; 8'ha1: r = 8'h32; 8'ha2: r = 8'h3a; 8'ha3: r = 8'h0a; 8'ha4: r = 8'h49; 8'ha5: r = 8'h06; 8'ha6: r = 8'h24; 8'ha7: r = 8'h5c;
            8'ha8: r = 8'hc2; 8'ha9: r = 8'hd3; 8'haa: r = 8'hac; 8'hab: r = 8'h62; 8'hac: r = 8'h91; 8'had: r = 8'h95; 8'hae: r = 8'he4; 8'haf: r = 8'h79;
            8'hb0: r = 8'he7; 8'hb1: r = 8'hc8; 8'hb2: r = 8'h37; 8'hb3: r = 8'h6d; 8'hb4: r = 8'h8d; 8'hb5: r = 8'hd5; 8'hb6: r = 8'h4e; 8'hb7: r = 8'ha9;
            8'hb8: r = 8'h6c; 8'hb9: r = 8'h56; 8'hba: r = 8'hf4; 8'hbb: r = 8'hea; 8'hbc: r = 8'h65; 8'hbd: r = 8'h7a; 8'hbe: r = 8'hae; 8'hbf: r = 8'h08;
            8'hc0: r = 8'hba; 8'hc1: r = 8'h78; 8'hc2: r = 8'h25; 8'hc3: r = 8'h2e; 8'hc4: r = 8'h1c; 8'hc5: r = 8'ha6; 8'hc6: r = 8'hb4; 8'hc7: r = 8'hc6;
            8'hc8: r = 8'he8; 8'hc9: r = 8'hdd; 8'hca: r = 8'h74; 8'hcb: r = 8'h1f; 8'hcc: r = 8'h4b; 8'hcd: r = 8'hbd; 8'hce: r = 8'h8b; 8'hcf: r = 8'h8a;
            8'hd0: r = 8'h70; 8'hd1: r = 8'h3e; 8'hd2: r = 8'hb5; 8'hd3: r = 8'h66; 8'hd4: r = 8'h48; 8'hd5: r = 8'h03; 8'hd6: r = 8'hf6; 8'hd7: r = 8'h0e;
            8'hd8: r = 8'h61; 8'hd9: r = 8'h35; 8'hda: r = 8'h57; 8'hdb: r = 8'hb9; 8'hdc: r = 8'h86; 8'hdd: r = 8'hc1; 8'hde: r = 8'h1d; 8'hdf: r = 8'h9e;
            8'he0: r = 8'he1; 8'he1: r = 8'hf8; 8'he2: r = 8'h98; 8'he3: r = 8'h11; 8'he4: r = 8'h69; 8'he5: r = 8'hd9; 8'he6: r = 8'h8e; 8'he7: r = 8'h94;
            8'he8: r = 8'h9b; 8'he9: r = 8'h1e; 8'hea: r = 8'h87; 8'heb: r = 8'he9; 8'hec: r = 8'hce; 8'hed: r = 8'h55; 8'hee: r = 8'h28; 8'hef: r = 8'hdf;
            8'hf0: r = 8'h8c; 8'hf1: r = 8'ha1; 8'hf2: r = 8'h89; 8'hf3: r = 8'h0d; 8'hf4: r = 8'hbf; 8'hf5: r = 8'he6; 8'hf6: r = 8'h42; 8'hf7: r = 8'h68;
            8'hf8: r = 8'h41; 8'hf9: r = 8'h99; 8'hfa: r = 8'h2d; 8'hfb: r = 8'h0f; 8'hfc: r = 8'hb0; 8'hfd: r = 8'h54; 8'hfe: r = 8'hbb; 8'hff: r = 8'h16;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        logic [7:0] r;
        r = 8'h00;
        case (b)
            8'h00: r = 8'h52; 8'h01: r = 8'h09; 8'h02: r = 8'h6a; 8'h03: r = 8'hd5; 8'h04: r = 8'h30; 8'h05: r = 8'h36; 8'h06: r = 8'ha5; 8'h07: r = 8'h38;
            8'h08: r = 8'hbf; 8'h09: r = 8'h40; 8'h0a: r = 8'ha3; 8'h0b: r = 8'h9e; 8'h0c: r = 8'h81; 8'h0d: r = 8'hf3; 8'h0e: r = 8'hd7; 8'h0f: r = 8'hfb;
            8'h10: r = 8'h7c; 8'h11: r = 8'he3; 8'h12: r = 8'h39; 8'h13: r = 8'h82; 8'h14: r = 8'h9b; 8'h15: r = 8'h2f; 8'h16: r = 8'hff; 8'h17: r = 8'h87;
            8'h18: r = 8'h34; 8'h19: r = 8'h8e; 8'h1a: r = 8'h43; 8'h1b: r = 8'h44; 8'h1c: r = 8'hc4; 8'h1d: r = 8'hde; 8'h1e: r = 8'he9; 8'h1f: r = 8'hcb;
            8'h20: r = 8'h54; 8'h21: r = 8'h7b; 8'h22: r = 8'h94; 8'h23: r = 8'h32; 8'h24: r = 8'ha6; 8'h25: r = 8'hc2; 8'h26: r = 8'h23; 8'h27: r = 8'h3d;
            8'h28: r = 8'hee; 8'h29: r = 8'h4c; 8'h2a: r = 8'h95; 8'h2b: r = 8'h0b; 8'h2c: r = 8'h42; 8'h2d: r = 8'hfa; 8'h2e: r = 8'hc3; 8'h2f: r = 8'h4e;
            8'h30: r = 8'h08; 8'h31: r = 8'h2e; 8'h32: r = 8'ha1; 8'h33: r = 8'h66; 8'h34: r = 8'h28; 8'h35: r = 8'hd9; 8'h36: r = 8'h24; 8'h37: r = 8'hb2;
            8'h38: r = 8'h76; 8'h39: r = 8'h5b; 8'h3a: r = 8'ha2; 8'h3b: r = 8'h49; 8'h3c: r = 8'h6d; 8'h3d: r = 8'h8b; 8'h3e: r = 8'hd1; 8'h3f: r = 8'h25;
            8'h40: r = 8'h72; 8'h41: r = 8'hf8; 8'h42: r = 8'hf6; 8'h43: r = 8'h64; 8'h44: r = 8'h86; 8'h45: r = 8'h68; 8'h46: r = 8'h98; 8'h47: r = 8'h16;
            8'h48: r = 8'hd4; 8'h49: r = 8'ha4; 8'h4a: r = 8'h5c; 8'h4b: r = 8'hcc; 8'h4c: r = 8'h5d; 8'h4d: r = 8'h65; 8'h4e: r = 8'hb6; 8'h4f: r = 8'h92;
            8'h50: r = 8'h6c; 8'h51: r = 8'h70; 8'h52: r = 8'h48; 8'h53: r = 8'h50; 8'h54: r = 8'hfd; 8'h55: r = 8'hed; 8'h56: r = 8'hb9; 8'h57: r = 8'hda;
            8'h58: r = 8'h5e; 8'h59: r = 8'h15; 8'h5a: r = 8'h46; 8'h5b: r = 8'h57; 8'h5c: r = 8'ha7; 8'h5d: r = 8'h8d; 8'h5e: r = 8'h9d; 8'h5f: r = 8'h84;
            8'h60: r = 8'h90; 8'h61: r = 8'hd8; 8'h62: r = 8'hab; 8'h63: r = 8'h00; 8'h64: r = 8'h8c; 8'h65: r = 8'hbc; 8'h66: r = 8'hd3; 8'h67: r = 8'h0a;
            8'h68: r = 8'hf7; 8'h69: r = 8'he4; 8'h6a: r = 8'h58; 8'h6b: r = 8'h05; 8'h6c: r = 8'hb8; 8'h6d: r = 8'hb3; 8'h6e: r = 8'h45; 8'h6f: r = 8'h06;
            8'h70: r = 8'hd0; 8'h71: r = 8'h2c; 8'h72: r = 8'h1e; 8'h73: r = 8'h8f; 8'h74: r = 8'hca; 8'h75: r = 8'h3f; 8'h76: r = 8'h0f; 8'h77: r = 8'h02;
            8'h78: r = 8'hc1; 8'h79: r = 8'haf; 8'h7a: r = 8'hbd; 8'h7b: r = 8'h03; 8'h7c: r = 8'h01; 8'h7d: r = 8'h13; 8'h7e: r = 8'h8a; 8'h7f: r = 8'h6b;
            8'h80: r = 8'h3a; 8'h81: r = 8'h91; 8'h82: r = 8'h11; 8'h83: r = 8'h41; 8'h84: r = 8'h4f; 8'h85: r = 8'h67; 8'h86: r = 8'hdc; 8'h87: r = 8'hea;
            8'h88: r = 8'h97; 8'h89: r = 8'hf2; 8'h8a: r = 8'hcf; 8'h8b: r = 8'hce; 8'h8c: r = 8'hf0; 8'h8d: r = 8'hb4; 8'h8e: r = 8'he6; 8'h8f: r = 8'h73;
            8'h90: r = 8'h96; 8'h91: r = 8'hac; 8'h92: r = 8'h74; 8'h93: r = 8'h22; 8'h94: r = 8'he7; 8'h95: r = 8'had; 8'h96: r = 8'h35; 8'h97: r = 8'h85;
            8'h98: r = 8'he2; 8'h99: r = 8'hf9; 8'h9a: r = 8'h37; 8'h9b: r = 8'he8; 8'h9c: r = 8'h1c; 8'h9d: r = 8'h75; 8'h9e: r = 8'hdf; 8'h9f: r = 8'h6e;
            8'ha0: r = 8'h47; 8'ha1: r = 8'hf1; 8'ha2: r = 8'h1a; 8'ha3: r = 8'h71; 8'ha4: r = 8'h1d; 8'ha5: r = 8'h29; 8'ha6: r = 8'hc5; 8'ha7: r = 8'h89;
            8'ha8: r = 8'h6f; 8'ha9: r = 8'hb7; 8'haa: r = 8'h62; 8'hab: r = 8'h0e; 8'hac: r = 8'haa; 8'had: r = 8'h18; 8'hae: r = 8'hbe; 8'haf: r = 8'h1b;
            8'hb0: r = 8'hfc; 8'hb1: r = 8'h56; 8'hb2: r = 8'h3e; 8'hb3: r = 8'h4b; 8'hb4: r = 8'hc6; 8'hb5: r = 8'hd2; 8'hb6: r = 8'h79; 8'hb7: r = 8'h20;
            8'hb8: r = 8'h9a; 8'hb9: r = 8'hdb; 8'hba: r = 8'hc0; 8'hbb: r = 8'hfe; 8'hbc: r = 8'h78; 8'hbd: r = 8'hcd; 8'hbe: r = 8'h5a; 8'hbf: r = 8'hf4;
            8'hc0: r = 8'h1f; 8'hc1: r = 8'hdd; 8'hc2: r = 8'ha8; 8'hc3: r = 8'h33; 8'hc4: r = 8'h88; 8'hc5: r = 8'h07; 8'hc6: r = 8'hc7; 8'hc7: r = 8'h31;
            8'hc8: r = 8'hb1; 8'hc9: r = 8'h12; 8'hca: r = 8'h10; 8'hcb: r = 8'h59; 8'hcc: r = 8'h27; 8'hcd: r = 8'h80; 8'hce: r = 8'hec; 8'hcf: r = 8'h5f;
            8'hd0: r = 8'h60; 8'hd1: r = 8'h51; 8'hd2: r = 8'h7f; 8'hd3: r = 8'ha9; 8'hd4: r = 8'h19; 8'hd5: r = 8'hb5; 8'hd6: r = 8'h4a; 8'hd7: r = 8'h0d;
            8'hd8: r = 8'h2d; 8'hd9: r = 8'he5; 8'hda: r = 8'h7a; 8'hdb: r = 8'h9f; 8'hdc: r = 8'h93; 8'hdd: r = 8'hc9; 8'hde: r = 8'h9c; 8'hdf: r = 8'hef;
            8'he0: r = 8'ha0; 8'he1: r = 8'he0; 8'he2: r = 8'h3b; 8'he3: r = 8'h4d; 8'he4: r = 8'hae; 8'he5: r = 8'h2a; 8'he6: r = 8'hf5; 8'he7: r = 8'hb0;
            8'he8: r = 8'hc8; 8'he9: r = 8'heb; 8'hea: r = 8'hbb; 8'heb: r = 8'h3c; 8'hec: r = 8'h83; 8'hed: r = 8'h53; 8'hee: r = 8'h99; 8'hef: r = 8'h61;
            8'hf0: r = 8'h17; 8'hf1: r = 8'h2b; 8'hf2: r = 8'h04; 8'hf3: r = 8'h7e; 8'hf4: r = 8'hba; 8'hf5: r = 8'h77; 8'hf6: r = 8'hd6; 8'hf7: r = 8'h26;
            8'hf8: r = 8'he1; 8'hf9: r = 8'h69; 8'hfa: r = 8'h14; 8'hfb: r = 8'h63; 8'hfc: r = 8'h55; 8'hfd: r = 8'h21; 8'hfe: r = 8'h0c; 8'hff: r = 8'h7d;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/inv_subbytes_seq_if.sv
// Input and output valid/ready handshakes of the InvSubBytes engine.
// The engine takes the slave view; the producer/consumer side takes master.
interface inv_subbytes_seq_if;
    import aes_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic [8*NBYTES-1:0]   data;
    logic                  out_valid;
    logic                  out_ready;
    logic [8*NBYTES-1:0]   isb;

    modport master (
        output in_valid,
        output data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  isb
    );

    modport slave (
        input  in_valid,
        input  data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output isb
    );

endinterface

// File: rtl/inv_sbox_slice.sv
// Combinational inverse S-box applied to BYTES_PER_CYCLE bytes at once.
// Each byte is an independent table lookup.
module inv_sbox_slice
    import aes_pkg::*;
#(
    parameter int BYTES_PER_CYCLE = 4
) (
    input  logic [8*BYTES_PER_CYCLE-1:0] raw,
    output logic [8*BYTES_PER_CYCLE-1:0] sub
);

    // Replicate the lookup across every byte lane of the slice
    always_comb begin
        sub = '0;
        for (int i = 0; i < BYTES_PER_CYCLE; i++) begin
            sub[8*i +: 8] = inv_sbox(raw[8*i +: 8]);
        end
    end

endmodule

// File: rtl/inv_subbytes_seq.sv
// Iterative AES InvSubBytes engine: latches a state word and rewrites it
// one slice per clock, then holds the result until the consumer takes it.
module inv_subbytes_seq
    import aes_pkg::*;
#(
    parameter int BYTES_PER_CYCLE = 4
) (
    input  logic              clk,
    input  logic              rst,
    inv_subbytes_seq_if.slave bus
);

    localparam int NPASS = NBYTES / BYTES_PER_CYCLE;
    localparam int CW    = (NPASS > 1) ? $clog2(NPASS) : 1;
    localparam int SW    = 8 * BYTES_PER_CYCLE;

    state_t              state;
    state_t              state_nxt;
    logic [CW-1:0]       cnt;
    logic [8*NBYTES-1:0] work;
    logic [SW-1:0]       raw;
    logic [SW-1:0]       sub;
    logic                accept;
    logic                last;
    logic                drain;

    assign accept = (state == IDLE) && bus.in_valid;
    assign last   = (cnt == CW'(NPASS - 1));
    assign drain  = (state == DONE) && bus.out_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state: IDLE -> RUN on accept, RUN -> DONE on last slice,
    // DONE -> IDLE once the result is taken
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if (last)   state_nxt = DONE;
            DONE:    if (drain)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decode from state only
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        unique case (state)
            IDLE:    bus.in_ready  = 1'b1;
            DONE:    bus.out_valid = 1'b1;
            default: ;
        endcase
    end

    assign bus.isb = work;

    // Select the slice addressed by the pass counter
    always_comb begin
        raw = '0;
        for (int p = 0; p < NPASS; p++) begin
            if (CW'(p) == cnt) raw = work[p*SW +: SW];
        end
    end

    inv_sbox_slice #(
        .BYTES_PER_CYCLE(BYTES_PER_CYCLE)
    ) u_slice (
        .raw(raw),
        .sub(sub)
    );

    // Working register and pass counter: load on accept, rewrite in RUN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            work <= '0;
        end else if (accept) begin
            cnt  <= '0;
            work <= bus.data;
        end else if (state == RUN) begin
            cnt <= cnt + 1'b1;
            for (int p = 0; p < NPASS; p++) begin
                if (CW'(p) == cnt) work[p*SW +: SW] <= sub;
            end
        end
    end

endmodule
